// File: rtl/writeback_unit_if.sv
// Writeback bus: ALU and load result sources plus the register-file write port.
interface writeback_unit_if;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned REG_AW  = 5;

    logic              alu_valid_i;
    logic              alu_ready_o;
    logic [REG_AW-1:0] alu_rd_i;
    logic [XLEN-1:0]   alu_data_i;

    logic              ld_valid_i;
    logic              ld_ready_o;
    logic [REG_AW-1:0] ld_rd_i;
    logic [XLEN-1:0]   ld_data_i;
    logic [1:0]        ld_size_i;
    logic              ld_unsigned_i;
    logic [2:0]        ld_offset_i;

    logic [REG_AW-1:0] rd_addr_o;
    logic              wr_en_o;
    logic [XLEN-1:0]   wr_data_o;

    // Producer side: offers results and observes the register-file write.
    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_valid_i, ld_rd_i, ld_data_i, ld_size_i, ld_unsigned_i, ld_offset_i,
        input  alu_ready_o, ld_ready_o,
        input  rd_addr_o, wr_en_o, wr_data_o
    );

    // Writeback unit side.
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_valid_i, ld_rd_i, ld_data_i, ld_size_i, ld_unsigned_i, ld_offset_i,
        output alu_ready_o, ld_ready_o,
        output rd_addr_o, wr_en_o, wr_data_o
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: round-robin arbitration between ALU and load results,
// load alignment/extension, and a registered register-file write port.
module writeback_unit (
    input  logic               clk,
    input  logic               reset,
    writeback_unit_if.slave    bus
);
    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        LAST_LD  = 1'b0,
        LAST_ALU = 1'b1
    } last_grant_e;

    last_grant_e state_q;
    last_grant_e state_d;

    logic alu_grant;
    logic ld_grant;
    logic alu_xfer;
    logic ld_xfer;

    logic [2:0]      eff_off;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_result;

    // Arbiter pointer register; reset favours the ALU on the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LAST_LD;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer advances only when a handshake completes.
    always_comb begin
        state_d = state_q;
        if (alu_xfer) begin
            state_d = LAST_ALU;
        end else if (ld_xfer) begin
            state_d = LAST_LD;
        end
    end

    // Grants: a lone requester wins, a tie goes to the source not served last.
    always_comb begin
        alu_grant = 1'b0;
        ld_grant  = 1'b0;
        if (reset) begin
            alu_grant = bus.alu_valid_i && (!bus.ld_valid_i || (state_q == LAST_LD));
            ld_grant  = bus.ld_valid_i && (!bus.alu_valid_i || (state_q == LAST_ALU));
        end
    end

    assign bus.alu_ready_o = alu_grant;
    assign bus.ld_ready_o  = ld_grant;
    assign alu_xfer        = alu_grant;
    assign ld_xfer         = ld_grant;

    // Effective byte offset: naturally align to the access size.
    always_comb begin
        eff_off = bus.ld_offset_i;
        unique case (bus.ld_size_i)
            2'b00:   eff_off = bus.ld_offset_i;
            2'b01:   eff_off = {bus.ld_offset_i[2:1], 1'b0};
            2'b10:   eff_off = {bus.ld_offset_i[2], 2'b00};
            default: eff_off = 3'b000;
        endcase
    end

    assign ld_shifted = bus.ld_data_i >> {eff_off, 3'b000};

    // Truncate the shifted doubleword to the access size and extend to 64 bits.
    always_comb begin
        ld_result = ld_shifted;
        unique case (bus.ld_size_i)
            2'b00: ld_result = bus.ld_unsigned_i ? {56'd0, ld_shifted[7:0]}
                                                 : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01: ld_result = bus.ld_unsigned_i ? {48'd0, ld_shifted[15:0]}
                                                 : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            2'b10: ld_result = bus.ld_unsigned_i ? {32'd0, ld_shifted[31:0]}
                                                 : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_result = ld_shifted;
        endcase
    end

    // Registered write port; x0 transfers complete but never enable the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.wr_en_o   <= 1'b0;
            bus.rd_addr_o <= '0;
            bus.wr_data_o <= '0;
        end else if (alu_xfer) begin
            bus.wr_en_o   <= (bus.alu_rd_i != REG_AW'(0));
            bus.rd_addr_o <= bus.alu_rd_i;
            bus.wr_data_o <= bus.alu_data_i;
        end else if (ld_xfer) begin
            bus.wr_en_o   <= (bus.ld_rd_i != REG_AW'(0));
            bus.rd_addr_o <= bus.ld_rd_i;
            bus.wr_data_o <= ld_result;
        end else begin
            bus.wr_en_o   <= 1'b0;
        end
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-004 alu_valid_i  input  1  ALU result offered.
REQ-005 alu_ready_o  output  1  ALU result accepted this cycle.
REQ-006 alu_rd_i  input  5  ALU destination register.
REQ-007 alu_data_i  input  64  ALU result.
REQ-008 ld_valid_i  input  1  load result offered.
REQ-009 ld_ready_o  output  1  load result accepted this cycle.
REQ-010 ld_rd_i  input  5  load destination register.
REQ-011 ld_data_i  input  64  raw aligned doubleword from memory, little-endian.
REQ-012 ld_size_i  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-013 ld_unsigned_i  input  1  1 = zero-extend, 0 = sign-extend.
REQ-014 ld_offset_i  input  3  byte offset within the doubleword.
REQ-015 rd_addr_o  output  5  register-file write address.
REQ-016 wr_en_o  output  1  register-file write enable.
REQ-017 wr_data_o  output  64  register-file write data.

Function
REQ-018 A transfer occurs on a source when its valid and ready are both 1 at a rising clk edge.
REQ-019 ready outputs SHALL be combinational from valids and the arbiter pointer; at most one ready is 1 per cycle.
REQ-020 Only one valid: that source SHALL be granted (ready=1), with no wait state.
REQ-021 Both valid: the source not granted on the most recent transfer SHALL be granted (round-robin).
REQ-022 The arbiter pointer SHALL update only on a transfer; idle cycles leave it unchanged.
REQ-023 A source held off SHALL keep valid and payload stable until granted; the block never drops an offered result.
REQ-024 Outputs are registered: a transfer at edge N SHALL appear on rd_addr_o/wr_data_o with wr_en_o=1 for exactly the cycle after edge N.
REQ-025 No transfer at an edge: wr_en_o SHALL be 0 the following cycle; rd_addr_o and wr_data_o hold their last values.
REQ-026 A transfer with destination x0 SHALL be accepted (handshake completes, pointer updates) but wr_en_o stays 0.
REQ-027 ALU path: wr_data_o = alu_data_i unmodified.
REQ-028 Load path effective offset: byte uses ld_offset_i; half clears bit 0; word clears bits 1:0; double uses 0.
REQ-029 Load path: field = ld_data_i shifted right by 8*offset, truncated to 8/16/32/64 bits per ld_size_i.
REQ-030 Field SHALL be sign-extended to 64 bits when ld_unsigned_i=0, zero-extended when 1; for double, ld_unsigned_i has no effect.
REQ-031 Back-to-back transfers on consecutive edges SHALL give wr_en_o=1 on consecutive cycles (throughput 1 write/cycle).

Reset
REQ-032 While reset=0: wr_en_o=0, rd_addr_o=0, wr_data_o=0, alu_ready_o=0, ld_ready_o=0, asynchronously.
REQ-033 Reset SHALL set the arbiter pointer so ALU wins the first tie.
REQ-034 Reset asserted mid-operation SHALL clear wr_en_o immediately, discarding any pending write; no transfer occurs while reset=0.
REQ-035 First transfer possible at the first rising edge after reset deasserts.

Verification
REQ-036 ALU only: alu_valid=1, rd=5, data=0x1234 -> alu_ready=1; next cycle wr_en=1, rd_addr=5, wr_data=0x1234.
REQ-037 Signed byte: ld_data=0x0000_0000_0080_0000, size=00, offset=2, unsigned=0 -> wr_data=0xFFFF_FFFF_FFFF_FF80; unsigned=1 -> 0x80.
REQ-038 Word alignment: ld_data=0x8765_4321_0000_0000, size=10, offset=5 -> effective offset 4; signed -> 0xFFFF_FFFF_8765_4321.
REQ-039 Tie: both valid for 4 cycles after reset -> grants ALU, load, ALU, load; wr_en=1 on 4 consecutive cycles with matching rd/data.
REQ-040 x0: alu_valid=1, rd=0 -> alu_ready=1, wr_en stays 0; the next tie grants load.
REQ-041 Reset mid-stream: reset=0 in the cycle after a transfer -> wr_en_o=0 and readies=0 at once; after release the ALU wins the first tie.
